jk_count_ctrl: RTL and testbench

Sequencing controller that sits directly upstream of a WIDTH-bit JKFF bank and drives its `_J`/`_K`/`_E` inputs. It reads the bank's `_Q` back and issues one-cycle enable strobes to count the register up or down by a requested number of steps, or to parallel-load it. This gives the stdlib a counter built from the JKFF primitive without modifying that primitive.

---
 rtl/jk_count_ctrl_if.sv | 25 ++
 rtl/jk_count_ctrl.sv | 128 ++++++++++++
 tb/tb_jk_count_ctrl.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/jk_count_ctrl_if.sv
// Request/response bundle between a client and the JKFF count controller.
interface jk_count_ctrl_if #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned STEPW = 8
);
   logic             _start;
   logic             _load;
   logic             _dir;
   logic [STEPW-1:0] _steps;
   logic [WIDTH-1:0] _data;
   logic             _busy;
   logic             _done;
   logic             _wrap;
   logic             _return;

   modport master (
      output _start, _load, _dir, _steps, _data,
      input  _busy, _done, _wrap, _return
   );

   modport slave (
      input  _start, _load, _dir, _steps, _data,
      output _busy, _done, _wrap, _return
   );
endinterface

// File: rtl/jk_count_ctrl.sv
// Sequencer that counts or parallel-loads a JKFF bank by strobing its J/K/E inputs,
// one step every two cycles so each mask is derived from the settled Q.
module jk_count_ctrl #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned STEPW = 8
) (
   input  logic             _clock,
   input  logic             _reset,
   jk_count_ctrl_if.slave   bus,
   input  logic [WIDTH-1:0] _Q,
   output logic [WIDTH-1:0] _J,
   output logic [WIDTH-1:0] _K,
   output logic [WIDTH-1:0] _E
);

   typedef enum logic [1:0] {StIdle, StIssue, StSettle} state_e;

   state_e           state_q, state_d;
   logic [STEPW-1:0] rem_q, rem_d;
   logic             dir_q, dir_d;
   logic [WIDTH-1:0] j_q, j_d, k_q, k_d, e_q, e_d;
   logic             done_q, done_d;
   logic             wrap_q, wrap_d;

   // Bits that flip on one increment (up) or decrement (down) of q.
   function automatic logic [WIDTH-1:0] step_mask(input logic [WIDTH-1:0] q, input logic up);
      logic [WIDTH-1:0] m;
      logic             run;
      m   = '0;
      run = 1'b1;
      for (int i = 0; i < WIDTH; i++) begin
         m[i] = run;
         run  = run & (up ? q[i] : ~q[i]);
      end
      return m;
   endfunction

   // A step from all-ones (up) or zero (down) wraps the register.
   function automatic logic wrap_hit(input logic [WIDTH-1:0] q, input logic up);
      return up ? (&q) : ~(|q);
   endfunction

   // Next-state, next strobe values and status flags.
   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      dir_d   = dir_q;
      j_d     = '0;
      k_d     = '0;
      e_d     = '0;
      done_d  = 1'b0;
      wrap_d  = wrap_q;
      unique case (state_q)
         StIdle: begin
            if (bus._start) begin
               if (bus._load) begin
                  j_d     = bus._data;
                  k_d     = ~bus._data;
                  e_d     = '1;
                  wrap_d  = 1'b0;
                  rem_d   = STEPW'(1);
                  state_d = StIssue;
               end else if (bus._steps != '0) begin
                  dir_d   = bus._dir;
                  rem_d   = bus._steps;
                  e_d     = step_mask(_Q, bus._dir);
                  j_d     = e_d;
                  k_d     = e_d;
                  wrap_d  = wrap_hit(_Q, bus._dir);
                  state_d = StIssue;
               end else begin
                  wrap_d = 1'b0;
                  done_d = 1'b1;
               end
            end
         end
         StIssue: begin
            if (rem_q != '0) rem_d = rem_q - STEPW'(1);
            state_d = StSettle;
         end
         StSettle: begin
            if (rem_q != '0) begin
               e_d     = step_mask(_Q, dir_q);
               j_d     = e_d;
               k_d     = e_d;
               wrap_d  = wrap_q | wrap_hit(_Q, dir_q);
               state_d = StIssue;
            end else begin
               done_d  = 1'b1;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State and registered outputs; reset aborts any operation in progress.
   always_ff @(posedge _clock) begin
      if (_reset) begin
         state_q <= StIdle;
         rem_q   <= '0;
         dir_q   <= 1'b0;
         j_q     <= '0;
         k_q     <= '0;
         e_q     <= '0;
         done_q  <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         dir_q   <= dir_d;
         j_q     <= j_d;
         k_q     <= k_d;
         e_q     <= e_d;
         done_q  <= done_d;
         wrap_q  <= wrap_d;
      end
   end

   assign _J          = j_q;
   assign _K          = k_q;
   assign _E          = e_q;
   assign bus._busy   = (state_q != StIdle);
   assign bus._done   = done_q;
   assign bus._return = done_q;
   assign bus._wrap   = wrap_q;

endmodule

// File: tb/tb_jk_count_ctrl.sv
// Directed bench: controller driving a behavioural JKFF bank.
module tb_jk_count_ctrl;
   localparam int unsigned WIDTH = 8;
   localparam int unsigned STEPW = 8;

   logic             clock;
   logic             reset;
   logic [WIDTH-1:0] bank_q;
   logic [WIDTH-1:0] j, k, e;
   int               total;
   int               bad;
   int               done_seen;

   jk_count_ctrl_if #(.WIDTH(WIDTH), .STEPW(STEPW)) bus ();

   jk_count_ctrl #(.WIDTH(WIDTH), .STEPW(STEPW)) dut (
      ._clock (clock),
      ._reset (reset),
      .bus    (bus),
      ._Q     (bank_q),
      ._J     (j),
      ._K     (k),
      ._E     (e)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // JKFF bank: E=1 with J=K=1 toggles, J=1,K=0 sets, J=0 clears; E=0 holds.
   always @(posedge clock) begin
      if (reset) bank_q <= '0;
      else begin
         for (int i = 0; i < WIDTH; i++) begin
            if (e[i]) bank_q[i] <= j[i] ? (k[i] ? ~bank_q[i] : 1'b1) : 1'b0;
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic req(input logic ld, input logic dr, input logic [STEPW-1:0] st,
                      input logic [WIDTH-1:0] dt);
      bus._start = 1'b1;
      bus._load  = ld;
      bus._dir   = dr;
      bus._steps = st;
      bus._data  = dt;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b1;
      bus._start = 1'b0;
      bus._load  = 1'b0;
      bus._dir   = 1'b0;
      bus._steps = '0;
      bus._data  = '0;
      tick();
      tick();
      chk("rst_e", 32'(e), 32'h0);
      chk("rst_j", 32'(j), 32'h0);
      chk("rst_k", 32'(k), 32'h0);
      chk("rst_busy", 32'(bus._busy), 32'h0);
      chk("rst_done", 32'(bus._done), 32'h0);
      chk("rst_wrap", 32'(bus._wrap), 32'h0);
      chk("rst_ret", 32'(bus._return), 32'h0);
      reset = 1'b0;
      tick();

      // Load 0xA5
      req(1'b1, 1'b0, 8'd7, 8'hA5);
      tick();
      bus._start = 1'b0;
      chk("ld_j", 32'(j), 32'hA5);
      chk("ld_k", 32'(k), 32'h5A);
      chk("ld_e", 32'(e), 32'hFF);
      chk("ld_busy1", 32'(bus._busy), 32'h1);
      tick();
      chk("ld_e2", 32'(e), 32'h0);
      chk("ld_q2", 32'(bank_q), 32'hA5);
      chk("ld_done2", 32'(bus._done), 32'h0);
      tick();
      chk("ld_done3", 32'(bus._done), 32'h1);
      chk("ld_ret3", 32'(bus._return), 32'h1);
      chk("ld_busy3", 32'(bus._busy), 32'h0);

      // Preload 0x06, then count up 3
      req(1'b1, 1'b0, 8'd0, 8'h06);
      tick();
      bus._start = 1'b0;
      tick();
      tick();
      chk("pre06", 32'(bank_q), 32'h06);
      req(1'b0, 1'b1, 8'd3, 8'h00);
      tick();
      bus._start = 1'b0;
      chk("up_e1", 32'(e), 32'h01);
      chk("up_jk1", 32'({j, k}), 32'h0101);
      tick();
      chk("up_q2", 32'(bank_q), 32'h07);
      chk("up_e2", 32'(e), 32'h0);
      tick();
      chk("up_e3", 32'(e), 32'h0F);
      tick();
      chk("up_q4", 32'(bank_q), 32'h08);
      tick();
      chk("up_e5", 32'(e), 32'h01);
      tick();
      chk("up_q6", 32'(bank_q), 32'h09);
      chk("up_busy6", 32'(bus._busy), 32'h1);
      chk("up_done6", 32'(bus._done), 32'h0);
      tick();
      chk("up_done7", 32'(bus._done), 32'h1);
      chk("up_wrap7", 32'(bus._wrap), 32'h0);
      chk("up_busy7", 32'(bus._busy), 32'h0);

      // Down 1 from 0x00 wraps
      reset = 1'b1;
      tick();
      reset = 1'b0;
      req(1'b0, 1'b0, 8'd1, 8'h00);
      tick();
      bus._start = 1'b0;
      chk("dn_e1", 32'(e), 32'hFF);
      tick();
      chk("dn_q2", 32'(bank_q), 32'hFF);
      tick();
      chk("dn_done3", 32'(bus._done), 32'h1);
      chk("dn_wrap3", 32'(bus._wrap), 32'h1);

      // Zero steps: immediate done, no strobes, wrap cleared
      req(1'b0, 1'b1, 8'd0, 8'h00);
      tick();
      bus._start = 1'b0;
      chk("z_done1", 32'(bus._done), 32'h1);
      chk("z_busy1", 32'(bus._busy), 32'h0);
      chk("z_e1", 32'(e), 32'h0);
      chk("z_wrap1", 32'(bus._wrap), 32'h0);
      tick();
      chk("z_done2", 32'(bus._done), 32'h0);
      chk("z_q2", 32'(bank_q), 32'hFF);

      // Up 4 from 0x10 with ignored and accepted re-starts
      req(1'b1, 1'b0, 8'd0, 8'h10);
      tick();
      bus._start = 1'b0;
      tick();
      tick();
      req(1'b0, 1'b1, 8'd4, 8'h00);
      tick();
      bus._start = 1'b0;
      chk("u4_e1", 32'(e), 32'h01);
      tick();
      req(1'b1, 1'b0, 8'd0, 8'h00);
      tick();
      bus._start = 1'b0;
      chk("u4_e3", 32'(e), 32'h03);
      tick();
      chk("u4_q4", 32'(bank_q), 32'h12);
      tick();
      chk("u4_e5", 32'(e), 32'h01);
      tick();
      tick();
      chk("u4_e7", 32'(e), 32'h07);
      tick();
      chk("u4_q8", 32'(bank_q), 32'h14);
      tick();
      chk("u4_done9", 32'(bus._done), 32'h1);
      chk("u4_q9", 32'(bank_q), 32'h14);
      req(1'b0, 1'b0, 8'd1, 8'h00);
      tick();
      bus._start = 1'b0;
      chk("re_busy", 32'(bus._busy), 32'h1);
      chk("re_e", 32'(e), 32'h07);
      tick();
      tick();
      chk("re_done", 32'(bus._done), 32'h1);
      chk("re_q", 32'(bank_q), 32'h13);

      // Reset in cycle 3 of a 5-step count aborts
      reset = 1'b1;
      tick();
      reset = 1'b0;
      req(1'b0, 1'b1, 8'd5, 8'h00);
      tick();
      bus._start = 1'b0;
      tick();
      tick();
      chk("ab_e3", 32'(e), 32'h03);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("ab_jke4", 32'({j, k, e}), 32'h0);
      chk("ab_busy4", 32'(bus._busy), 32'h0);
      chk("ab_done4", 32'(bus._done), 32'h0);
      chk("ab_q4", 32'(bank_q), 32'h00);
      done_seen = 0;
      for (int c = 0; c < 12; c++) begin
         tick();
         if (bus._done) done_seen++;
      end
      chk("ab_nodone", 32'(done_seen), 32'h0);
      chk("ab_qend", 32'(bank_q), 32'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1);
   end
endmodule
